execute_stage: RTL and testbench
================================

# execute_stage

Pipeline EX stage of the TPFINAL processor. It takes decoded operands and control from the ID/EX register and resolves data hazards by forwarding from EX/MEM and MEM/WB. It derives the 4-bit ALU operation, drives the ALU, and registers the result plus downstream control into the EX/MEM boundary. Its output is the EX/MEM pipeline register.

## Interface
- PROC_BITS, 32 (from constants.vh): datapath width.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  0 = stall; outputs hold.
- i_flush  in  1  1 = load a bubble.
- i_rs_data, i_rt_data  in  PROC_BITS  register-file operands.
- i_imm  in  PROC_BITS  sign-extended immediate; upper-half placement is done by the ALU LUI op.
- i_rs_addr, i_rt_addr, i_rd_addr  in  5  source and destination register numbers.
- i_shamt  in  5  shift amount field.
- i_funct  in  6  R-type function field.
- i_alu_op  in  3  class: 0 R-type, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LUI, 7 SLT.
- i_alu_src  in  1  operand B select: 0 = rt, 1 = imm.
- i_reg_dst  in  1  destination select: 1 = rd, 0 = rt.
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  in  1 each  control bits passed downstream.
- i_exmem_reg_write  in  1  EX/MEM forwarding source: write enable.
- i_exmem_rd  in  5  EX/MEM forwarding source: destination register.
- i_exmem_result  in  PROC_BITS  EX/MEM forwarding source: value.
- i_memwb_reg_write  in  1  MEM/WB forwarding source: write enable.
- i_memwb_rd  in  5  MEM/WB forwarding source: destination register.
- i_memwb_data  in  PROC_BITS  MEM/WB forwarding source: value.
- o_alu_result, o_store_data  out  PROC_BITS  registered.
- o_write_reg  out  5  registered.
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg  out  1  registered.

## Operation

**Forwarding** (per operand rs and rt):
- Use i_exmem_result if i_exmem_reg_write, i_exmem_rd != 0 and i_exmem_rd equals the operand address.
- Otherwise use i_memwb_data under the same rules with the MEM/WB signals.
- Otherwise use the register-file value.
- EX/MEM wins when both match. Register 0 is never forwarded.

**ALU operand A:**
- sll/srl/sra: zero-extended i_shamt.
- sllv/srlv/srav: forwarded rs[4:0], zero-extended.
- Otherwise: forwarded rs.

**ALU operand B:** i_alu_src ? i_imm : forwarded rt.

**Store data:** forwarded rt, independent of i_alu_src.

**ALU operation:**
- i_alu_op 1..7 maps directly to ADD, SUB, AND, OR, XOR, LUI, SLT.
- For R-type, i_funct maps as follows:
  - 0x20/0x21 ADD, 0x22/0x23 SUB
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT
  - 0x00/0x04 SLL, 0x02/0x06 SRL, 0x03/0x07 SRA
- Any other funct selects ADD and forces o_reg_write = 0.
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLL 7, SRL 8, SRA 9, LUI 10.

**Arithmetic:** wraps modulo 2^PROC_BITS, no overflow trap. SLT is signed.

**Destination:** o_write_reg = i_reg_dst ? i_rd_addr : i_rt_addr.

## Timing
- Single register stage: inputs sampled at rising edge N appear on outputs after edge N; latency 1 cycle.
- Forwarding and ALU paths are combinational within the cycle.
- Priority at each edge: i_rst > i_flush > !i_enable > load.
- Reset: every output 0; the first post-reset cycle is a bubble.
- Flush: all outputs 0 (bubble), regardless of i_enable.
- Stall (i_enable=0, no flush): all outputs hold their previous value. Forwarding inputs are ignored for the held value.
- Reset asserted mid-stream clears outputs at that edge; no pending state survives.

## Structure
- Shared in constants.vh:
  - PROC_BITS
  - ALU operation codes
  - i_alu_op class codes
  - funct codes
- Sub-module alu_control: combinational; (i_alu_op, i_funct) -> 4-bit operation, shift-source select, illegal flag.
- Instantiates the team ALU module (i_dataA, i_dataB, i_operation, o_result).
- Forwarding muxes and the output register live in execute_stage.

## Test plan
- **R-type add, no hazards:** rs_data=-55, rt_data=8, funct 0x20, reg_dst=1, rd=3, reg_write=1 → next cycle o_alu_result=-47, o_write_reg=3, o_reg_write=1.
- **Shift immediate vs variable:**
  - sll, shamt=5, rt=40 → 1280.
  - srav, rs=5, rt=-85 → -3.
  - sra, shamt=5, rs=99, rt=85 → 2 (rs ignored).
- **Forwarding:**
  - rs_addr=4; exmem_rd=4 (value 100); memwb_rd=4 (value 7); both reg_write=1; add with rt=1 → 101.
  - Same with exmem_rd=0 → 8.
  - Same with both rd=0 → register-file value used.
- **Immediate path:** alu_op=6 (LUI), imm=61 → o_alu_result=61<<16. alu_op=7 with rs=60, imm=50 → 0; with rs=40 → 1.
- **Store:** mem_write=1, alu_src=1, imm=8, rs=16, rt_addr=5 forwarded from MEM/WB value 0xAB → result 24, o_store_data=0xAB, o_mem_write=1.
- **Control sequencing:**
  - Stall 3 cycles with changing inputs → outputs frozen.
  - Flush during a stall → all outputs 0.
  - Illegal funct 0x3F → o_reg_write=0.
  - i_rst for one cycle mid-stream → all outputs 0 next cycle.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared constants for the EX stage: datapath width, ALU codes, op classes, funct codes.
package execute_stage_pkg;

  localparam int unsigned PROC_BITS = 32;

  typedef logic [3:0] alu_code_t;

  // ALU operation codes
  localparam alu_code_t ALU_ADD = 4'd0;
  localparam alu_code_t ALU_SUB = 4'd1;
  localparam alu_code_t ALU_AND = 4'd2;
  localparam alu_code_t ALU_OR  = 4'd3;
  localparam alu_code_t ALU_XOR = 4'd4;
  localparam alu_code_t ALU_NOR = 4'd5;
  localparam alu_code_t ALU_SLT = 4'd6;
  localparam alu_code_t ALU_SLL = 4'd7;
  localparam alu_code_t ALU_SRL = 4'd8;
  localparam alu_code_t ALU_SRA = 4'd9;
  localparam alu_code_t ALU_LUI = 4'd10;

  // i_alu_op class codes
  localparam logic [2:0] CLS_RTYPE = 3'd0;
  localparam logic [2:0] CLS_ADD   = 3'd1;
  localparam logic [2:0] CLS_SUB   = 3'd2;
  localparam logic [2:0] CLS_AND   = 3'd3;
  localparam logic [2:0] CLS_OR    = 3'd4;
  localparam logic [2:0] CLS_XOR   = 3'd5;
  localparam logic [2:0] CLS_LUI   = 3'd6;
  localparam logic [2:0] CLS_SLT   = 3'd7;

  // R-type funct codes
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  // Where ALU operand A comes from
  typedef enum logic [1:0] {
    ShiftSrcRs,
    ShiftSrcShamt,
    ShiftSrcRsLow
  } shift_src_e;

  // EX/MEM beats MEM/WB; register 0 is never forwarded.
  function automatic logic [PROC_BITS-1:0] forward_operand(
    input logic [4:0]           addr,
    input logic [PROC_BITS-1:0] rf_data,
    input logic                 exmem_we,
    input logic [4:0]           exmem_rd,
    input logic [PROC_BITS-1:0] exmem_data,
    input logic                 memwb_we,
    input logic [4:0]           memwb_rd,
    input logic [PROC_BITS-1:0] memwb_data
  );
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == addr)) begin
      return exmem_data;
    end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == addr)) begin
      return memwb_data;
    end
    return rf_data;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, forwarding sources and EX/MEM outputs of the execute stage.
interface execute_stage_if;
  import execute_stage_pkg::*;

  logic                 i_enable;
  logic                 i_flush;
  logic [PROC_BITS-1:0] i_rs_data;
  logic [PROC_BITS-1:0] i_rt_data;
  logic [PROC_BITS-1:0] i_imm;
  logic [4:0]           i_rs_addr;
  logic [4:0]           i_rt_addr;
  logic [4:0]           i_rd_addr;
  logic [4:0]           i_shamt;
  logic [5:0]           i_funct;
  logic [2:0]           i_alu_op;
  logic                 i_alu_src;
  logic                 i_reg_dst;
  logic                 i_reg_write;
  logic                 i_mem_read;
  logic                 i_mem_write;
  logic                 i_mem_to_reg;
  logic                 i_exmem_reg_write;
  logic [4:0]           i_exmem_rd;
  logic [PROC_BITS-1:0] i_exmem_result;
  logic                 i_memwb_reg_write;
  logic [4:0]           i_memwb_rd;
  logic [PROC_BITS-1:0] i_memwb_data;

  logic [PROC_BITS-1:0] o_alu_result;
  logic [PROC_BITS-1:0] o_store_data;
  logic [4:0]           o_write_reg;
  logic                 o_reg_write;
  logic                 o_mem_read;
  logic                 o_mem_write;
  logic                 o_mem_to_reg;

  modport master (
    output i_enable, i_flush, i_rs_data, i_rt_data, i_imm, i_rs_addr, i_rt_addr, i_rd_addr,
           i_shamt, i_funct, i_alu_op, i_alu_src, i_reg_dst, i_reg_write, i_mem_read,
           i_mem_write, i_mem_to_reg, i_exmem_reg_write, i_exmem_rd, i_exmem_result,
           i_memwb_reg_write, i_memwb_rd, i_memwb_data,
    input  o_alu_result, o_store_data, o_write_reg, o_reg_write, o_mem_read, o_mem_write,
           o_mem_to_reg
  );

  modport slave (
    input  i_enable, i_flush, i_rs_data, i_rt_data, i_imm, i_rs_addr, i_rt_addr, i_rd_addr,
           i_shamt, i_funct, i_alu_op, i_alu_src, i_reg_dst, i_reg_write, i_mem_read,
           i_mem_write, i_mem_to_reg, i_exmem_reg_write, i_exmem_rd, i_exmem_result,
           i_memwb_reg_write, i_memwb_rd, i_memwb_data,
    output o_alu_result, o_store_data, o_write_reg, o_reg_write, o_mem_read, o_mem_write,
           o_mem_to_reg
  );

endinterface

// File: rtl/alu.sv
// Team ALU: purely combinational, operation selected by a 4-bit code.
module alu
  import execute_stage_pkg::*;
(
  input  logic [PROC_BITS-1:0] i_dataA,
  input  logic [PROC_BITS-1:0] i_dataB,
  input  alu_code_t            i_operation,
  output logic [PROC_BITS-1:0] o_result
);

  // Shifts take the amount from A and shift B; LUI places B in the upper half.
  always_comb begin
    o_result = '0;
    case (i_operation)
      ALU_ADD: o_result = i_dataA + i_dataB;
      ALU_SUB: o_result = i_dataA - i_dataB;
      ALU_AND: o_result = i_dataA & i_dataB;
      ALU_OR:  o_result = i_dataA | i_dataB;
      ALU_XOR: o_result = i_dataA ^ i_dataB;
      ALU_NOR: o_result = ~(i_dataA | i_dataB);
      ALU_SLT: o_result[0] = $signed(i_dataA) < $signed(i_dataB);
      ALU_SLL: o_result = i_dataB << i_dataA[4:0];
      ALU_SRL: o_result = i_dataB >> i_dataA[4:0];
      ALU_SRA: o_result = $signed(i_dataB) >>> i_dataA[4:0];
      ALU_LUI: o_result = i_dataB << 16;
      default: o_result = i_dataA + i_dataB;
    endcase
  end

endmodule

// File: rtl/execute_stage_alu_control.sv
// Decodes the op class and funct field into an ALU code, operand-A source and illegal flag.
module execute_stage_alu_control
  import execute_stage_pkg::*;
(
  input  logic [2:0] i_alu_op,
  input  logic [5:0] i_funct,
  output alu_code_t  o_operation,
  output shift_src_e o_shift_src,
  output logic       o_illegal
);

  // Class decode; R-type falls through to the funct table.
  always_comb begin
    o_operation = ALU_ADD;
    o_shift_src = ShiftSrcRs;
    o_illegal   = 1'b0;
    case (i_alu_op)
      CLS_RTYPE: begin
        case (i_funct)
          FUNCT_ADD, FUNCT_ADDU: o_operation = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: o_operation = ALU_SUB;
          FUNCT_AND:             o_operation = ALU_AND;
          FUNCT_OR:              o_operation = ALU_OR;
          FUNCT_XOR:             o_operation = ALU_XOR;
          FUNCT_NOR:             o_operation = ALU_NOR;
          FUNCT_SLT:             o_operation = ALU_SLT;
          FUNCT_SLL: begin o_operation = ALU_SLL; o_shift_src = ShiftSrcShamt; end
          FUNCT_SRL: begin o_operation = ALU_SRL; o_shift_src = ShiftSrcShamt; end
          FUNCT_SRA: begin o_operation = ALU_SRA; o_shift_src = ShiftSrcShamt; end
          FUNCT_SLLV: begin o_operation = ALU_SLL; o_shift_src = ShiftSrcRsLow; end
          FUNCT_SRLV: begin o_operation = ALU_SRL; o_shift_src = ShiftSrcRsLow; end
          FUNCT_SRAV: begin o_operation = ALU_SRA; o_shift_src = ShiftSrcRsLow; end
          default: begin o_operation = ALU_ADD; o_illegal = 1'b1; end
        endcase
      end
      CLS_SUB: o_operation = ALU_SUB;
      CLS_AND: o_operation = ALU_AND;
      CLS_OR:  o_operation = ALU_OR;
      CLS_XOR: o_operation = ALU_XOR;
      CLS_LUI: o_operation = ALU_LUI;
      CLS_SLT: o_operation = ALU_SLT;
      default: o_operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// EX pipeline stage: operand forwarding, ALU, and the EX/MEM output register.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  execute_stage_if.slave ex
);

  logic [PROC_BITS-1:0] fwd_rs;
  logic [PROC_BITS-1:0] fwd_rt;
  logic [PROC_BITS-1:0] alu_a;
  logic [PROC_BITS-1:0] alu_b;
  logic [PROC_BITS-1:0] alu_result;
  alu_code_t            alu_operation;
  shift_src_e           shift_src;
  logic                 illegal;

  execute_stage_alu_control u_alu_control (
    .i_alu_op    (ex.i_alu_op),
    .i_funct     (ex.i_funct),
    .o_operation (alu_operation),
    .o_shift_src (shift_src),
    .o_illegal   (illegal)
  );

  // Forwarded operands and ALU operand selection
  always_comb begin
    fwd_rs = forward_operand(ex.i_rs_addr, ex.i_rs_data, ex.i_exmem_reg_write, ex.i_exmem_rd,
                             ex.i_exmem_result, ex.i_memwb_reg_write, ex.i_memwb_rd,
                             ex.i_memwb_data);
    fwd_rt = forward_operand(ex.i_rt_addr, ex.i_rt_data, ex.i_exmem_reg_write, ex.i_exmem_rd,
                             ex.i_exmem_result, ex.i_memwb_reg_write, ex.i_memwb_rd,
                             ex.i_memwb_data);
    case (shift_src)
      ShiftSrcShamt: alu_a = PROC_BITS'(ex.i_shamt);
      ShiftSrcRsLow: alu_a = PROC_BITS'(fwd_rs[4:0]);
      default:       alu_a = fwd_rs;
    endcase
    alu_b = ex.i_alu_src ? ex.i_imm : fwd_rt;
  end

  alu u_alu (
    .i_dataA     (alu_a),
    .i_dataB     (alu_b),
    .i_operation (alu_operation),
    .o_result    (alu_result)
  );

  // EX/MEM register: reset and flush load a bubble, stall holds
  always_ff @(posedge i_clk) begin
    if (i_rst || ex.i_flush) begin
      ex.o_alu_result <= '0;
      ex.o_store_data <= '0;
      ex.o_write_reg  <= '0;
      ex.o_reg_write  <= 1'b0;
      ex.o_mem_read   <= 1'b0;
      ex.o_mem_write  <= 1'b0;
      ex.o_mem_to_reg <= 1'b0;
    end else if (ex.i_enable) begin
      ex.o_alu_result <= alu_result;
      ex.o_store_data <= fwd_rt;
      ex.o_write_reg  <= ex.i_reg_dst ? ex.i_rd_addr : ex.i_rt_addr;
      ex.o_reg_write  <= ex.i_reg_write && !illegal;
      ex.o_mem_read   <= ex.i_mem_read;
      ex.o_mem_write  <= ex.i_mem_write;
      ex.o_mem_to_reg <= ex.i_mem_to_reg;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized traffic vs a model.
module tb_execute_stage;
  import execute_stage_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] store;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  out_t exp_q = '0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  execute_stage_if bus ();

  execute_stage dut (
    .i_clk (clk),
    .i_rst (rst),
    .ex    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (bus.i_exmem_reg_write && bus.i_exmem_rd != 5'd0 && bus.i_exmem_rd == a)
      return bus.i_exmem_result;
    if (bus.i_memwb_reg_write && bus.i_memwb_rd != 5'd0 && bus.i_memwb_rd == a)
      return bus.i_memwb_data;
    return rf;
  endfunction

  // Instruction-level reference: what the EX/MEM register holds after the next edge.
  function automatic out_t model(input out_t prev);
    out_t o;
    logic [31:0] a, rt, b, r;
    logic legal;
    if (rst || bus.i_flush) return '0;
    if (!bus.i_enable) return prev;
    a = fwd(bus.i_rs_addr, bus.i_rs_data);
    rt = fwd(bus.i_rt_addr, bus.i_rt_data);
    b = bus.i_alu_src ? bus.i_imm : rt;
    legal = 1'b1;
    case (bus.i_alu_op)
      3'd0: begin
        case (bus.i_funct)
          6'h20, 6'h21: r = a + b;
          6'h22, 6'h23: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h26: r = a ^ b;
          6'h27: r = ~(a | b);
          6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: r = b << bus.i_shamt;
          6'h02: r = b >> bus.i_shamt;
          6'h03: r = 32'($signed(b) >>> bus.i_shamt);
          6'h04: r = b << a[4:0];
          6'h06: r = b >> a[4:0];
          6'h07: r = 32'($signed(b) >>> a[4:0]);
          default: begin r = a + b; legal = 1'b0; end
        endcase
      end
      3'd1: r = a + b;
      3'd2: r = a - b;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = {b[15:0], 16'h0000};
      default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    o.res   = r;
    o.store = rt;
    o.wr    = bus.i_reg_dst ? bus.i_rd_addr : bus.i_rt_addr;
    o.rw    = bus.i_reg_write && legal;
    o.mr    = bus.i_mem_read;
    o.mw    = bus.i_mem_write;
    o.m2r   = bus.i_mem_to_reg;
    return o;
  endfunction

  task automatic clear_in();
    rst = 1'b0;
    bus.i_enable = 1'b1; bus.i_flush = 1'b0;
    bus.i_rs_data = '0; bus.i_rt_data = '0; bus.i_imm = '0;
    bus.i_rs_addr = '0; bus.i_rt_addr = '0; bus.i_rd_addr = '0;
    bus.i_shamt = '0; bus.i_funct = 6'h20; bus.i_alu_op = '0;
    bus.i_alu_src = 1'b0; bus.i_reg_dst = 1'b0; bus.i_reg_write = 1'b0;
    bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0; bus.i_mem_to_reg = 1'b0;
    bus.i_exmem_reg_write = 1'b0; bus.i_exmem_rd = '0; bus.i_exmem_result = '0;
    bus.i_memwb_reg_write = 1'b0; bus.i_memwb_rd = '0; bus.i_memwb_data = '0;
  endtask

  task automatic rand_data();
    logic [5:0] functs [16];
    functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h3F};
    bus.i_rs_data = $urandom; bus.i_rt_data = $urandom; bus.i_imm = $urandom;
    bus.i_rs_addr = 5'($urandom_range(0, 3)); bus.i_rt_addr = 5'($urandom_range(0, 3));
    bus.i_rd_addr = 5'($urandom); bus.i_shamt = 5'($urandom);
    bus.i_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 15)];
    bus.i_alu_op = 3'($urandom); bus.i_alu_src = 1'($urandom); bus.i_reg_dst = 1'($urandom);
    bus.i_reg_write = 1'($urandom); bus.i_mem_read = 1'($urandom);
    bus.i_mem_write = 1'($urandom); bus.i_mem_to_reg = 1'($urandom);
    bus.i_exmem_reg_write = 1'($urandom); bus.i_exmem_rd = 5'($urandom_range(0, 3));
    bus.i_exmem_result = $urandom;
    bus.i_memwb_reg_write = 1'($urandom); bus.i_memwb_rd = 5'($urandom_range(0, 3));
    bus.i_memwb_data = $urandom;
  endtask

  // One clock: predict, let the edge pass, compare every output.
  task automatic cycle();
    out_t nxt;
    nxt = model(exp_q);
    @(posedge clk);
    #1;
    check_eq("alu_result", bus.o_alu_result, nxt.res);
    check_eq("store_data", bus.o_store_data, nxt.store);
    check_eq("write_reg", 32'(bus.o_write_reg), 32'(nxt.wr));
    check_eq("reg_write", 32'(bus.o_reg_write), 32'(nxt.rw));
    check_eq("mem_read", 32'(bus.o_mem_read), 32'(nxt.mr));
    check_eq("mem_write", 32'(bus.o_mem_write), 32'(nxt.mw));
    check_eq("mem_to_reg", 32'(bus.o_mem_to_reg), 32'(nxt.m2r));
    exp_q = nxt;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    bus.i_reg_write = 1'b1; bus.i_rs_data = 32'd9;
    cycle();
    check_eq("reset_result", bus.o_alu_result, 32'd0);
    check_eq("reset_reg_write", 32'(bus.o_reg_write), 32'd0);

    // R-type add
    clear_in();
    bus.i_rs_data = 32'hFFFF_FFC9; bus.i_rt_data = 32'd8; bus.i_funct = 6'h20;
    bus.i_reg_dst = 1'b1; bus.i_rd_addr = 5'd3; bus.i_reg_write = 1'b1;
    bus.i_rs_addr = 5'd1; bus.i_rt_addr = 5'd2;
    cycle();
    check_eq("add_result", bus.o_alu_result, 32'hFFFF_FFD1);
    check_eq("add_write_reg", 32'(bus.o_write_reg), 32'd3);
    check_eq("add_reg_write", 32'(bus.o_reg_write), 32'd1);

    // Shifts
    clear_in(); bus.i_funct = 6'h00; bus.i_shamt = 5'd5; bus.i_rt_data = 32'd40;
    cycle();
    check_eq("sll_result", bus.o_alu_result, 32'd1280);
    clear_in(); bus.i_funct = 6'h07; bus.i_rs_data = 32'd5; bus.i_rt_data = 32'hFFFF_FFAB;
    cycle();
    check_eq("srav_result", bus.o_alu_result, 32'hFFFF_FFFD);
    clear_in(); bus.i_funct = 6'h03; bus.i_shamt = 5'd5; bus.i_rs_data = 32'd99;
    bus.i_rt_data = 32'd85;
    cycle();
    check_eq("sra_result", bus.o_alu_result, 32'd2);

    // Forwarding priority
    clear_in();
    bus.i_rs_addr = 5'd4; bus.i_rs_data = 32'd55; bus.i_rt_addr = 5'd9; bus.i_rt_data = 32'd1;
    bus.i_exmem_reg_write = 1'b1; bus.i_exmem_rd = 5'd4; bus.i_exmem_result = 32'd100;
    bus.i_memwb_reg_write = 1'b1; bus.i_memwb_rd = 5'd4; bus.i_memwb_data = 32'd7;
    cycle();
    check_eq("fwd_exmem", bus.o_alu_result, 32'd101);
    bus.i_exmem_rd = 5'd0;
    cycle();
    check_eq("fwd_memwb", bus.o_alu_result, 32'd8);
    bus.i_memwb_rd = 5'd0;
    cycle();
    check_eq("fwd_none", bus.o_alu_result, 32'd56);

    // Immediate path
    clear_in(); bus.i_alu_op = 3'd6; bus.i_alu_src = 1'b1; bus.i_imm = 32'd61;
    cycle();
    check_eq("lui_result", bus.o_alu_result, 32'd61 << 16);
    clear_in(); bus.i_alu_op = 3'd7; bus.i_alu_src = 1'b1; bus.i_imm = 32'd50;
    bus.i_rs_data = 32'd60;
    cycle();
    check_eq("slt_false", bus.o_alu_result, 32'd0);
    bus.i_rs_data = 32'd40;
    cycle();
    check_eq("slt_true", bus.o_alu_result, 32'd1);

    // Store with forwarded data
    clear_in(); bus.i_alu_op = 3'd1; bus.i_mem_write = 1'b1; bus.i_alu_src = 1'b1;
    bus.i_imm = 32'd8; bus.i_rs_addr = 5'd2; bus.i_rs_data = 32'd16;
    bus.i_rt_addr = 5'd5; bus.i_rt_data = 32'h11;
    bus.i_memwb_reg_write = 1'b1; bus.i_memwb_rd = 5'd5; bus.i_memwb_data = 32'hAB;
    cycle();
    check_eq("store_result", bus.o_alu_result, 32'd24);
    check_eq("store_data_fwd", bus.o_store_data, 32'hAB);
    check_eq("store_mem_write", 32'(bus.o_mem_write), 32'd1);

    // Stall with changing inputs
    for (int i = 0; i < 3; i++) begin
      rand_data(); bus.i_enable = 1'b0; bus.i_flush = 1'b0;
      cycle();
      check_eq("stall_result", bus.o_alu_result, 32'd24);
      check_eq("stall_store", bus.o_store_data, 32'hAB);
    end

    // Flush during stall
    bus.i_flush = 1'b1;
    cycle();
    check_eq("flush_result", bus.o_alu_result, 32'd0);
    check_eq("flush_mem_write", 32'(bus.o_mem_write), 32'd0);

    // Illegal funct
    clear_in(); bus.i_funct = 6'h3F; bus.i_reg_write = 1'b1; bus.i_rs_data = 32'd3;
    bus.i_rt_data = 32'd4;
    cycle();
    check_eq("illegal_reg_write", 32'(bus.o_reg_write), 32'd0);
    check_eq("illegal_result", bus.o_alu_result, 32'd7);

    // Mid-stream reset
    clear_in(); bus.i_rs_data = 32'd10; bus.i_reg_write = 1'b1; bus.i_mem_read = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    check_eq("midrst_result", bus.o_alu_result, 32'd0);
    check_eq("midrst_mem_read", 32'(bus.o_mem_read), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_data();
      rst = ($urandom_range(0, 39) == 0);
      bus.i_flush = ($urandom_range(0, 19) == 0);
      bus.i_enable = ($urandom_range(0, 4) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
